// File: rtl/rtc_adj_if.sv
// rtc_adj_if: time adjustment request/acknowledge bundle between a servo and rtc_core.
interface rtc_adj_if;
  logic        adj_req_i;
  logic        adj_mode_i;
  logic        adj_neg_i;
  logic [47:0] adj_sec_i;
  logic [29:0] adj_ns_i;
  logic [5:0]  slew_rate_i;
  logic        adj_ack_o;
  logic        adj_busy_o;
  logic        adj_done_o;
  modport master (
    output adj_req_i, adj_mode_i, adj_neg_i, adj_sec_i, adj_ns_i, slew_rate_i,
    input  adj_ack_o, adj_busy_o, adj_done_o
  );
  modport slave (
    input  adj_req_i, adj_mode_i, adj_neg_i, adj_sec_i, adj_ns_i, slew_rate_i,
    output adj_ack_o, adj_busy_o, adj_done_o
  );
endinterface

// File: rtl/rtc_core.sv
// rtc_core: free-running PTP real-time clock with absolute set, signed step and monotonic slew.
module rtc_core #(
  parameter int          FNS_W        = 26,
  parameter int          SC2NS        = 1000000000,
  parameter logic [31:0] TICK_INC_DEF = 32'h2000_0000
) (
  input  logic         rtc_clk,
  input  logic         rtc_rst,
  input  logic         tick_wr_i,
  input  logic [31:0]  tick_inc_i,
  input  logic         set_i,
  input  logic [47:0]  set_sec_i,
  input  logic [31:0]  set_ns_i,
  rtc_adj_if.slave     adj,
  output logic [79:0]  rtc_std_o,
  output logic [15:0]  rtc_fns_o,
  output logic [31:0]  tick_inc_o,
  output logic         sec_pulse_o
);
  localparam logic [31:0] SC = 32'(SC2NS);
  typedef enum logic {IDLE, SLEW} state_t;
  state_t state, state_nx;
  logic [47:0] sec, sec_nx, mag_sec;
  logic [31:0] ns, ns_nx, sum_ns, t, p, mag_ns, lim, rate_raw, rate_c, rate_e;
  logic [FNS_W-1:0] frac;
  logic [31+FNS_W:0] sum;
  logic [29:0] rem, rem_nx, extra;
  logic [5:0] rate_r;
  logic neg_r, neg, c1, c2, b, accept, step, busy, done, done_nx;
  always_comb begin
    sum = {ns, frac} + {{FNS_W{1'b0}}, tick_inc_o};
    sum_ns = sum[31+FNS_W:FNS_W];
    c1 = sum_ns >= SC;
    t = c1 ? sum_ns - SC : sum_ns;
    accept = state == IDLE && adj.adj_req_i && !set_i;
    step = accept && !adj.adj_mode_i;
    // negative slew is clamped below one tick so the clock never runs backwards
    lim = 32'(tick_inc_o[31:FNS_W]) - 32'd1;
    rate_raw = rate_r == '0 ? 32'd1 : 32'(rate_r);
    rate_c = neg_r && lim < rate_raw ? lim : rate_raw;
    rate_e = rate_c == '0 ? 32'd1 : rate_c;
    extra = 32'(rem) < rate_e ? rem : rate_e[29:0];
    mag_ns = step ? {2'b0, adj.adj_ns_i} : state == SLEW ? {2'b0, extra} : '0;
    mag_sec = step ? adj.adj_sec_i : '0;
    neg = step ? adj.adj_neg_i : neg_r;
    p = t + mag_ns;
    c2 = p >= SC;
    b = t < mag_ns;
    ns_nx = neg ? t - mag_ns + (b ? SC : '0) : (c2 ? p - SC : p);
    sec_nx = neg ? sec + 48'(c1) - mag_sec - 48'(b) : sec + mag_sec + 48'(c1) + 48'(c2);
    rem_nx = state == SLEW ? rem - extra : accept && adj.adj_mode_i ? adj.adj_ns_i : rem;
    state_nx = state == SLEW ? (rem_nx == '0 ? IDLE : SLEW)
             : (accept && adj.adj_mode_i && adj.adj_ns_i != '0 ? SLEW : IDLE);
    done_nx = state == SLEW ? rem_nx == '0 : accept && (!adj.adj_mode_i || adj.adj_ns_i == '0);
  end
  always_ff @(posedge rtc_clk) begin
    if (rtc_rst) begin
      state <= IDLE;
      sec <= '0;
      ns <= '0;
      frac <= '0;
      tick_inc_o <= TICK_INC_DEF;
      sec_pulse_o <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      rem <= '0;
      neg_r <= 1'b0;
      rate_r <= '0;
    end else begin
      if (tick_wr_i && tick_inc_i[31:FNS_W] != '0) tick_inc_o <= tick_inc_i;
      if (accept) begin
        neg_r <= adj.adj_neg_i;
        rate_r <= adj.slew_rate_i;
      end
      sec <= set_i ? set_sec_i : sec_nx;
      ns <= set_i ? set_ns_i : ns_nx;
      frac <= set_i ? '0 : sum[FNS_W-1:0];
      sec_pulse_o <= !set_i && c1;
      state <= set_i ? IDLE : state_nx;
      busy <= !set_i && state_nx == SLEW;
      done <= !set_i && done_nx;
      rem <= rem_nx;
    end
  end
  assign rtc_std_o = {sec, ns};
  assign rtc_fns_o = frac[FNS_W-1:FNS_W-16];
  assign adj.adj_ack_o = accept && !rtc_rst;
  assign adj.adj_busy_o = busy;
  assign adj.adj_done_o = done;
endmodule

// File: tb/tb_rtc_core.sv
// tb_rtc_core: vector table, corner sequences and random traffic against a total-time reference model.
module tb_rtc_core;
  localparam logic [127:0] SC = 128'd1000000000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_wr = 1'b0;
  logic [31:0] tick_inc = '0;
  logic do_set = 1'b0;
  logic [47:0] set_sec = '0;
  logic [31:0] set_ns = '0;
  logic [79:0] rtc_std;
  logic [15:0] rtc_fns;
  logic [31:0] tick_out;
  logic sec_pulse;
  int checks = 0;
  int fails = 0;
  // model: time as one integer count of 2^-26 ns units modulo 2^48 seconds
  logic [127:0] T = '0;
  logic [127:0] M;
  logic [31:0] m_tick = 32'h2000_0000;
  logic m_busy = 1'b0, m_done = 1'b0, m_pulse = 1'b0, m_neg = 1'b0;
  logic [29:0] m_rem = '0;
  logic [5:0] m_rate = '0;
  rtc_adj_if ifc();
  rtc_core dut (
    .rtc_clk(clk), .rtc_rst(rst), .tick_wr_i(tick_wr), .tick_inc_i(tick_inc),
    .set_i(do_set), .set_sec_i(set_sec), .set_ns_i(set_ns), .adj(ifc),
    .rtc_std_o(rtc_std), .rtc_fns_o(rtc_fns), .tick_inc_o(tick_out), .sec_pulse_o(sec_pulse)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic mode, neg;
    logic [47:0] sec0;
    logic [31:0] ns0;
    logic [47:0] asec;
    logic [29:0] ans;
    logic [5:0] rate;
    logic [47:0] xsec;
    logic [31:0] xns;
    logic xpulse;
    int xbusy;
  } vec_t;
  vec_t vt[7];
  function automatic logic [47:0] sec_of(logic [127:0] v);
    return 48'((v >> 26) / SC);
  endfunction
  function automatic logic [31:0] ns_of(logic [127:0] v);
    return 32'((v >> 26) % SC);
  endfunction
  task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask
  task automatic cyc();
    logic [127:0] tn, d;
    logic [31:0] ot, r, lim;
    logic [29:0] e;
    logic a;
    #1;
    a = !rst && !m_busy && ifc.adj_req_i && !do_set;
    chk("ack", ifc.adj_ack_o, a);
    if (rst) begin
      T = '0; m_tick = 32'h2000_0000; m_busy = 0; m_done = 0; m_pulse = 0; m_rem = '0;
    end else begin
      ot = m_tick;
      if (tick_wr && tick_inc[31:26] != '0) m_tick = tick_inc;
      m_done = 0;
      if (do_set) begin
        T = (128'(set_sec) * SC + 128'(set_ns)) << 26;
        m_busy = 0; m_pulse = 0;
      end else begin
        tn = (T + 128'(ot)) % M;
        m_pulse = sec_of(tn) != sec_of(T);
        if (a && !ifc.adj_mode_i) begin
          d = (128'(ifc.adj_sec_i) * SC + 128'(ifc.adj_ns_i)) << 26;
          tn = ifc.adj_neg_i ? (tn + M - d) % M : (tn + d) % M;
          m_done = 1;
        end else if (a) begin
          m_done = ifc.adj_ns_i == '0;
          m_busy = ifc.adj_ns_i != '0;
          m_rem = ifc.adj_ns_i; m_neg = ifc.adj_neg_i; m_rate = ifc.slew_rate_i;
        end else if (m_busy) begin
          r = m_rate == '0 ? 32'd1 : 32'(m_rate);
          lim = 32'(ot[31:26]) - 32'd1;
          if (m_neg && r > lim) r = lim;
          if (r == '0) r = 32'd1;
          e = 32'(m_rem) < r ? m_rem : r[29:0];
          d = 128'(e) << 26;
          tn = m_neg ? (tn + M - d) % M : (tn + d) % M;
          m_rem = m_rem - e;
          if (m_rem == '0) begin m_busy = 0; m_done = 1; end
        end
        T = tn;
      end
    end
    @(posedge clk);
    #1;
    chk("std", rtc_std, {sec_of(T), ns_of(T)});
    chk("fns", rtc_fns, T[25:10]);
    chk("tick", tick_out, m_tick);
    chk("pulse", sec_pulse, m_pulse);
    chk("busy", ifc.adj_busy_o, m_busy);
    chk("done", ifc.adj_done_o, m_done);
    if (a) ifc.adj_req_i = 0;
    do_set = 0;
    tick_wr = 0;
    @(negedge clk);
  endtask
  task automatic req(logic mode, logic neg, logic [47:0] s, logic [29:0] n, logic [5:0] r);
    ifc.adj_req_i = 1; ifc.adj_mode_i = mode; ifc.adj_neg_i = neg;
    ifc.adj_sec_i = s; ifc.adj_ns_i = n; ifc.slew_rate_i = r;
  endtask
  initial begin
    int nb, g;
    M = ((128'd1 << 48) * SC) << 26;
    req(0, 0, '0, '0, '0);
    ifc.adj_req_i = 0;
    vt[0] = '{0, 1, 48'd10, 32'd100, 48'd0, 30'd200, 6'd0, 48'd9, 32'd999_999_908, 0, 0};
    vt[1] = '{0, 0, 48'd0, 32'd999_999_996, 48'd2, 30'd999_999_990, 6'd0, 48'd3, 32'd999_999_994, 1, 0};
    vt[2] = '{1, 0, 48'd1, 32'd0, 48'd0, 30'd20, 6'd3, 48'd1, 32'd84, 0, 7};
    vt[3] = '{1, 1, 48'd1, 32'd0, 48'd0, 30'd20, 6'd10, 48'd1, 32'd12, 0, 3};
    vt[4] = '{0, 1, 48'd0, 32'd0, 48'd1, 30'd5, 6'd0, 48'hFFFF_FFFF_FFFF, 32'd3, 0, 0};
    vt[5] = '{1, 0, 48'd1, 32'd0, 48'd7, 30'd2, 6'd0, 48'd1, 32'd26, 0, 2};
    vt[6] = '{1, 0, 48'd1, 32'd0, 48'd0, 30'd0, 6'd5, 48'd1, 32'd8, 0, 0};
    cyc();
    rst = 0;
    // second rollover from a set time
    do_set = 1; set_sec = 48'd5; set_ns = 32'd999_999_992;
    cyc();
    chk("set_time", rtc_std, {48'd5, 32'd999_999_992});
    cyc();
    chk("roll_time", rtc_std, {48'd6, 32'd0});
    chk("roll_pulse", sec_pulse, 1'b1);
    cyc();
    chk("roll_pulse_once", sec_pulse, 1'b0);
    // fractional tick accumulation and ignored sub-ns write
    tick_wr = 1; tick_inc = 32'h1999_9999; do_set = 1; set_sec = '0; set_ns = '0;
    cyc();
    repeat (5) cyc();
    chk("frac_ns", rtc_std[31:0], 32'd31);
    chk("frac_fns", rtc_fns, 16'hFFFF);
    tick_wr = 1; tick_inc = 32'h0000_1000;
    cyc();
    chk("tick_ignored", tick_out, 32'h1999_9999);
    tick_wr = 1; tick_inc = 32'h2000_0000;
    cyc();
    foreach (vt[i]) begin
      do_set = 1; set_sec = vt[i].sec0; set_ns = vt[i].ns0;
      cyc();
      req(vt[i].mode, vt[i].neg, vt[i].asec, vt[i].ans, vt[i].rate);
      cyc();
      nb = 0; g = 0;
      while (!ifc.adj_done_o && g < 100) begin
        nb += int'(ifc.adj_busy_o);
        cyc();
        g++;
      end
      chk($sformatf("vec%0d_done", i), ifc.adj_done_o, 1'b1);
      chk($sformatf("vec%0d_time", i), rtc_std, {vt[i].xsec, vt[i].xns});
      chk($sformatf("vec%0d_pulse", i), sec_pulse, vt[i].xpulse);
      chk($sformatf("vec%0d_busycyc", i), nb, vt[i].xbusy);
      cyc();
      chk($sformatf("vec%0d_done_once", i), ifc.adj_done_o, 1'b0);
    end
    // set aborts a slew without completion
    req(1, 0, '0, 30'd50, 6'd1);
    repeat (3) cyc();
    chk("slew_busy", ifc.adj_busy_o, 1'b1);
    do_set = 1; set_sec = 48'd77; set_ns = 32'd5;
    cyc();
    chk("abort_busy", ifc.adj_busy_o, 1'b0);
    chk("abort_done", ifc.adj_done_o, 1'b0);
    chk("abort_time", rtc_std, {48'd77, 32'd5});
    cyc();
    chk("abort_done_late", ifc.adj_done_o, 1'b0);
    // reset during a slew
    req(1, 1, '0, 30'd60, 6'd2);
    repeat (3) cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_std", rtc_std, 80'd0);
    chk("rst_fns", rtc_fns, 16'd0);
    chk("rst_tick", tick_out, 32'h2000_0000);
    chk("rst_busy", ifc.adj_busy_o, 1'b0);
    chk("rst_done", ifc.adj_done_o, 1'b0);
    chk("rst_pulse", sec_pulse, 1'b0);
    cyc();
    chk("rst_no_done", ifc.adj_done_o, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 499) == 0;
      if ($urandom_range(0, 39) == 0) begin
        do_set = 1;
        set_sec = $urandom_range(0, 3) == 0 ? 48'hFFFF_FFFF_FFFF - 48'($urandom_range(0, 2))
                                            : 48'({$urandom, $urandom});
        set_ns = $urandom_range(0, 3) == 0 ? 32'd999_999_940 + $urandom_range(0, 59)
                                           : $urandom_range(0, 999_999_999);
      end
      if ($urandom_range(0, 29) == 0) begin
        tick_wr = 1;
        tick_inc = $urandom_range(0, 2) == 0 ? $urandom_range(0, 32'h03FF_FFFF) : $urandom;
      end
      if (!ifc.adj_req_i && $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0)
          req(0, 1'($urandom_range(0, 1)), 48'({$urandom, $urandom}),
              30'($urandom_range(0, 999_999_999)), 6'($urandom));
        else
          req(1, 1'($urandom_range(0, 1)), 48'({$urandom, $urandom}),
              30'($urandom_range(0, 300)), 6'($urandom));
      end
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/rtc_core.md
Name: rtc_core

Overview:
- Free-running real-time clock accumulator for the PTP timing path.
- Produces 48-bit seconds + 32-bit nanoseconds + 16-bit fractional nanoseconds, plus the active tick increment.
- Feeds the PPS/interval-pulse generation and PPS-input timestamping stage directly downstream.
- Supports absolute time set, one-shot signed step adjustment, and monotonic slew adjustment under a req/ack handshake.

Parameters:
FNS_W, 26, fractional-ns bits in tick increment and accumulator (tick format 6.26)
SC2NS, 1000000000, nanoseconds per second (rollover value)
TICK_INC_DEF, 32'h2000_0000, reset tick increment (8 ns)

Ports:
rtc_clk  in  1  RTC clock
rtc_rst  in  1  synchronous reset, active high
tick_wr_i  in  1  strobe: load tick_inc_i
tick_inc_i  in  32  new tick increment, 6.26 unsigned ns
set_i  in  1  strobe: load absolute time
set_sec_i  in  48  seconds to load
set_ns_i  in  32  nanoseconds to load (must be < SC2NS)
adj_req_i  in  1  adjustment request (level, held until adj_ack_o)
adj_mode_i  in  1  0 = step, 1 = slew
adj_neg_i  in  1  offset sign, 1 = subtract
adj_sec_i  in  48  offset seconds magnitude (step only)
adj_ns_i  in  30  offset ns magnitude (< SC2NS)
slew_rate_i  in  6  max extra ns per cycle in slew mode
adj_ack_o  out  1  one-cycle pulse: request accepted
adj_busy_o  out  1  slew in progress
adj_done_o  out  1  one-cycle pulse: adjustment completed
rtc_std_o  out  80  {seconds[47:0], ns[31:0]}
rtc_fns_o  out  16  accumulator fractional ns bits [FNS_W-1:FNS_W-16]
tick_inc_o  out  32  active tick increment
sec_pulse_o  out  1  one-cycle pulse on tick-driven second rollover

Behaviour:
- Reset (synchronous, rtc_rst=1 at edge): rtc_std_o=0, rtc_fns_o=0, tick_inc_o=TICK_INC_DEF, adj_ack_o=0, adj_busy_o=0, adj_done_o=0, sec_pulse_o=0; FSM to IDLE. Reset mid-slew discards the remaining offset; no adj_done.
- Accumulator: {ns[31:0], frac[FNS_W-1:0]}. Each cycle adds tick_inc_o, zero-extended.
- Tick-sum ns >= SC2NS: subtract SC2NS once, carry into seconds, assert sec_pulse_o that cycle (registered with the new time).
- Seconds wrap 2^48-1 -> 0.
- All outputs are registered. A change at cycle N is visible at N+1.
- tick_wr_i: tick_inc_o <= tick_inc_i only if tick_inc_i[31:FNS_W] != 0; otherwise the write is ignored. The new value is first used for accumulation in the cycle after the write.
- set_i has highest priority:
  - Next cycle: seconds=set_sec_i, ns=set_ns_i, frac=0 (no tick added that cycle); sec_pulse_o=0.
  - Aborts slew: adj_busy_o drops, no adj_done_o.
  - A coincident adj_req_i is not acked that cycle.
- FSM states: IDLE, SLEW.
- IDLE, adj_req_i=1, set_i=0: adj_ack_o pulses the same cycle, and the fields are sampled.
- Step (adj_mode_i=0), applied in the acceptance cycle:
  - t = ns + tick_ns (tick carry c1).
  - Positive: t + adj_ns, wrap >= SC2NS (c2); seconds += adj_sec + c1 + c2.
  - Negative: if t < adj_ns, then ns = t + SC2NS - adj_ns with borrow b; seconds = seconds + c1 - adj_sec - b.
  - Seconds arithmetic is mod 2^48.
  - adj_done_o pulses the next cycle; FSM stays IDLE.
  - sec_pulse_o reflects c1 only.
- Slew (adj_mode_i=1):
  - remaining <= adj_ns_i; adj_sec_i is ignored; adj_busy_o=1 from the next cycle; go to SLEW.
  - adj_ns_i=0: adj_done_o pulses immediately, FSM stays IDLE.
  - Per SLEW cycle: extra = min(remaining, rate), where rate = slew_rate_i, or for negative min(slew_rate_i, tick_ns-1) so time stays monotonic.
  - rate=0 is treated as 1.
  - Time = time + tick ± extra, with normal wrap/borrow; remaining -= extra.
  - When remaining reaches 0: adj_busy_o drops and adj_done_o pulses in the same registered cycle; return to IDLE.
- Requests while busy are not acked; the requester holds adj_req_i.
- tick_wr_i during slew is allowed; the negative clamp uses the current tick.

Test Plan:
- Reset, then set_i with sec=5, ns=999_999_992; tick 8 ns -> next cycle sec=5, ns=999_999_992; following cycle sec=6, ns=0, sec_pulse_o=1 for exactly one cycle.
- tick_wr_i=1 with 32'h1999_9999 (6.4 ns), then set time to 0 -> after 5 ticks ns=31, rtc_fns_o=16'hFFFF; write tick 32'h0000_1000 -> ignored, tick_inc_o unchanged.
- Time sec=10, ns=100, tick 8; step negative, 0 s, 200 ns -> sec=9, ns=999_999_908; ack same cycle; done one cycle later.
- Time sec=0, ns=999_999_996, tick 8; step positive, 2 s, 999_999_990 ns -> sec=3, ns=999_999_994, sec_pulse_o=1.
- Slew +20 ns, rate 3, tick 8 -> busy 7 cycles (extra 3,3,3,3,3,3,2); ns advances +20 beyond plain ticking; single adj_done_o.
- Slew -20 ns, rate 10, tick 8 -> clamped extras 7,7,6 over 3 cycles. Separately: set_i during slew -> busy drops, no done. Separately: rtc_rst mid-slew -> all outputs reset values.
